// File: rtl/alu_if.sv
// alu_if: request/result handshake bundle for alu_seq
interface alu_if #(parameter int W = 8);
  logic in_valid, in_ready, out_valid, out_ready, cout, ov, sign, zero, bad_op;
  logic [W-1:0] a, b, z, zh;
  logic [2:0] op;
  modport master (output in_valid, a, b, op, out_ready,
                  input in_ready, out_valid, z, zh, cout, ov, sign, zero, bad_op);
  modport slave (input in_valid, a, b, op, out_ready,
                 output in_ready, out_valid, z, zh, cout, ov, sign, zero, bad_op);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and zero flag
// ALU_MUL_EN builds the iterative shift-add multiplier for op 110; otherwise op 110 is flagged bad_op
module alu_seq #(parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  alu_if.slave s
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;
  logic take, ismul, last, rc, rov, rbad;
  logic [W:0] sum;
  logic [W-1:0] res;
  assign take = s.in_valid && s.in_ready;
  assign s.in_ready = state == IDLE;
  assign s.out_valid = state == DONE;
  assign s.sign = s.z[W-1];
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt;
  logic [W-1:0] ma, mb, acc, lo;
  logic [W:0] step;
  assign ismul = s.op == 3'b110;
  assign last = cnt == CW'(W - 1);
  // acc holds the running high half; product low bits shift into mb as b is consumed
  assign step = {1'b0, acc} + (mb[0] ? {1'b0, ma} : '0);
  assign lo = {step[0], mb[W-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0; ma <= '0; mb <= '0; acc <= '0;
    end else if (take) begin
      cnt <= '0; ma <= s.a; mb <= s.b; acc <= '0;
    end else if (state == MUL) begin
      cnt <= cnt + 1'b1; acc <= step[W:1]; mb <= lo;
    end
`else
  assign ismul = 1'b0;
  assign last = 1'b0;
`endif
  always_comb begin
    sum = s.op[0] ? {1'b0, s.a} + {1'b0, ~s.b} + 1'b1 : {1'b0, s.a} + {1'b0, s.b};
    res = '0;
    rc = 1'b0;
    rov = 1'b0;
    rbad = 1'b0;
    case (s.op)
      3'b000, 3'b001: begin
        res = sum[W-1:0];
        rc = sum[W];
        rov = ((s.a[W-1] ^ s.b[W-1]) == s.op[0]) && (sum[W-1] != s.a[W-1]);
      end
      3'b010: res = s.a & s.b;
      3'b011: res = s.a | s.b;
      3'b100: res = s.a ^ s.b;
      3'b101: res = ~s.a;
      3'b110: rbad = 1'b1;
      default: res = {{(W-1){1'b0}}, $signed(s.a) < $signed(s.b)};
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = take ? (ismul ? MUL : DONE) : IDLE;
      MUL: state_n = last ? DONE : MUL;
      DONE: state_n = s.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s.z <= '0; s.zh <= '0; s.cout <= 1'b0; s.ov <= 1'b0; s.zero <= 1'b0; s.bad_op <= 1'b0;
    end else begin
      state <= state_n;
      if (take && !ismul) begin
        s.z <= res; s.zh <= '0; s.cout <= rc; s.ov <= rov; s.zero <= res == '0; s.bad_op <= rbad;
      end
`ifdef ALU_MUL_EN
      else if (state == MUL && last) begin
        s.z <= lo; s.zh <= step[W:1]; s.cout <= |step[W:1]; s.ov <= 1'b0;
        s.zero <= lo == '0; s.bad_op <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors through a scoreboard queue; monitor checks each result as out_valid rises
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit HASMUL = 1'b1;
`else
  localparam bit HASMUL = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] z, zh;
    logic c, v, sg, zr, bd;
    int lat, acc;
  } exp_t;
  logic clk, rst_n;
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$];
  alu_if #(.W(W)) bus();
  alu_seq #(.W(W)) dut(.clk(clk), .rst_n(rst_n), .s(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [W-1:0] ia, ib, input logic [2:0] iop,
                       input logic [W-1:0] ez, ezh, input logic ec, ev, es, ezr, ebd,
                       input int elat, input bit push);
    exp_t e;
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.a = ia; bus.b = ib; bus.op = iop;
    e.z = ez; e.zh = ezh; e.c = ec; e.v = ev; e.sg = es; e.zr = ezr; e.bd = ebd;
    e.lat = elat; e.acc = cyc + 1;
    if (push) q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = ~ia; bus.b = ~ib;
  endtask
  task automatic issue_mul(input logic [W-1:0] ia, ib, ez, ezh, input bit push);
    if (HASMUL) issue(ia, ib, 3'b110, ez, ezh, |ezh, 1'b0, ez[W-1], ez == 0, 1'b0, W + 1, push);
    else issue(ia, ib, 3'b110, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, push);
  endtask
  initial begin
    exp_t e;
    logic pv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !pv) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result z=%0h", bus.z);
        end else begin
          e = q.pop_front();
          chk("z", {24'd0, bus.z}, {24'd0, e.z});
          chk("zh", {24'd0, bus.zh}, {24'd0, e.zh});
          chk("flags", {27'd0, bus.cout, bus.ov, bus.sign, bus.zero, bus.bad_op},
              {27'd0, e.c, e.v, e.sg, e.zr, e.bd});
          chk("latency", cyc - e.acc + 1, e.lat);
        end
      end
      pv = bus.out_valid;
    end
  end
  initial begin
    int n;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_outs", {bus.out_valid, bus.cout, bus.ov, bus.sign, bus.zero, bus.bad_op, bus.zh, bus.z},
        32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd100, 8'd124, 3'b000, 8'hE0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    issue(8'd110, 8'd200, 3'b000, 8'h36, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    issue(8'd110, 8'd200, 3'b001, 8'hA6, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    issue(8'd255, 8'd1, 3'b000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    issue(8'hF0, 8'h3C, 3'b010, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    issue(8'hA5, 8'h0F, 3'b011, 8'hAF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    issue(8'hFF, 8'hFF, 3'b100, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    issue(8'h00, 8'h5A, 3'b101, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    issue(8'd110, 8'd200, 3'b111, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    issue(8'd200, 8'd110, 3'b111, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    issue_mul(8'd100, 8'd124, 8'h70, 8'h30, 1'b1);
    issue_mul(8'd0, 8'hAB, 8'h00, 8'h00, 1'b1);
    issue_mul(8'd255, 8'd255, 8'h01, 8'hFE, 1'b1);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
    issue(8'd3, 8'd4, 3'b000, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    bus.in_valid = 1'b1; bus.a = 8'd9; bus.b = 8'd9; bus.op = 3'b001;
    repeat (5) begin
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_z", {24'd0, bus.z}, 32'd7);
      chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release_hold_z", {24'd0, bus.z}, 32'd7);
    issue_mul(8'd255, 8'd255, 8'h01, 8'hFE, !HASMUL);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_outs", {bus.out_valid, bus.cout, bus.ov, bus.sign, bus.zero, bus.bad_op, bus.zh, bus.z},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_mul(8'd255, 8'd255, 8'h01, 8'hFE, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
